// File: rtl/cache_pkg.sv
// Shared types and size helpers for the
// read-side cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    FILL,
    RESP
  } ctrl_state_t;

  function automatic int offset_size(
    input int block_size
  );
    return $clog2(block_size / 4);
  endfunction

  function automatic int set_size(
    input int num_sets
  );
    return $clog2(num_sets);
  endfunction

  function automatic int way_size(
    input int num_ways
  );
    return $clog2(num_ways);
  endfunction

  function automatic int tag_size(
    input int addr_size,
    input int num_sets,
    input int block_size
  );
    return addr_size - set_size(num_sets)
      - offset_size(block_size);
  endfunction

endpackage

// File: rtl/cache_victim_select.sv
// Per-set round-robin pointers and the
// victim-way choice for a miss fill.
module cache_victim_select
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4,
  localparam int SetSize = set_size(NUM_SETS),
  localparam int WaySize = way_size(NUM_WAYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SetSize-1:0] set,
  input  logic               populated,
  input  logic [WaySize-1:0] populate_way,
  input  logic               advance,
  output logic [WaySize-1:0] victim
);

  logic [WaySize-1:0] rr_ptr [NUM_SETS];

  // Power-of-two way count: the add wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SETS; i++)
        rr_ptr[i] <= '0;
    end else if (advance) begin
      rr_ptr[set] <= rr_ptr[set] + 1'b1;
    end
  end

  assign victim = populated ? rr_ptr[set]
                            : populate_way;

endmodule

// File: rtl/cache_controller.sv
// Blocking read controller: probe the array,
// fill a victim way on miss, then respond.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_SIZE  = 32,
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 4,
  parameter int BLOCK_SIZE = 32,
  localparam int OffsetSize =
    offset_size(BLOCK_SIZE),
  localparam int SetSize = set_size(NUM_SETS),
  localparam int TagSize =
    tag_size(ADDR_SIZE, NUM_SETS, BLOCK_SIZE),
  localparam int WaySize = way_size(NUM_WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [ADDR_SIZE-1:0]  cpu_req_addr,
  output logic                  cpu_resp_valid,
  input  logic                  cpu_resp_ready,
  output logic [BLOCK_SIZE-1:0] cpu_resp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_SIZE-1:0]  mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [BLOCK_SIZE-1:0] mem_resp_data,
  output logic [SetSize-1:0]    cache_set,
  output logic [TagSize-1:0]    cache_tag,
  output logic                  cache_write_enable,
  output logic [WaySize-1:0]    cache_write_way,
  output logic [BLOCK_SIZE-1:0] cache_write_data,
  input  logic [BLOCK_SIZE-1:0] cache_read_data,
  input  logic                  cache_hit,
  input  logic [WaySize-1:0]    cache_populate_way,
  input  logic                  cache_populated,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam logic [ADDR_SIZE-1:0] OffMask =
    ADDR_SIZE'((64'd1 << OffsetSize) - 64'd1);

  ctrl_state_t state;
  ctrl_state_t next;

  logic [ADDR_SIZE-1:0]  addr_q;
  logic [WaySize-1:0]    victim_q;
  logic                  evict_q;
  logic [BLOCK_SIZE-1:0] block_q;
  logic [BLOCK_SIZE-1:0] resp_q;
  logic [31:0]           hit_q;
  logic [31:0]           miss_q;
  logic [WaySize-1:0]    victim;
  logic                  advance;

  assign cache_set = addr_q[OffsetSize +: SetSize];
  assign cache_tag = addr_q[ADDR_SIZE-1 -: TagSize];
  assign mem_req_addr     = addr_q & ~OffMask;
  assign cache_write_way  = victim_q;
  assign cache_write_data = block_q;
  assign cpu_resp_data    = resp_q;
  assign hit_count        = hit_q;
  assign miss_count       = miss_q;

  // Pointer moves only when a valid way is replaced.
  assign advance = (state == FILL) && evict_q;

  cache_victim_select #(
    .NUM_SETS(NUM_SETS),
    .NUM_WAYS(NUM_WAYS)
  ) u_victim (
    .clk         (clk),
    .rst         (rst),
    .set         (cache_set),
    .populated   (cache_populated),
    .populate_way(cache_populate_way),
    .advance     (advance),
    .victim      (victim)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:
        if (cpu_req_valid) next = LOOKUP;
      LOOKUP:
        next = cache_hit ? RESP : MISS_REQ;
      MISS_REQ:
        if (mem_req_ready) next = MISS_WAIT;
      MISS_WAIT:
        if (mem_resp_valid) next = FILL;
      FILL:
        next = RESP;
      RESP:
        if (cpu_resp_ready) next = IDLE;
      default:
        next = IDLE;
    endcase
  end

  always_comb begin
    cpu_req_ready      = 1'b0;
    mem_req_valid      = 1'b0;
    cache_write_enable = 1'b0;
    cpu_resp_valid     = 1'b0;
    unique case (1'b1)
      state == IDLE:     cpu_req_ready      = 1'b1;
      state == MISS_REQ: mem_req_valid      = 1'b1;
      state == FILL:     cache_write_enable = 1'b1;
      state == RESP:     cpu_resp_valid     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      victim_q <= '0;
      evict_q  <= 1'b0;
      block_q  <= '0;
      resp_q   <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      if (state == IDLE && cpu_req_valid)
        addr_q <= cpu_req_addr;
      if (state == LOOKUP) begin
        if (cache_hit) begin
          resp_q <= cache_read_data;
          if (hit_q != 32'hFFFF_FFFF)
            hit_q <= hit_q + 32'd1;
        end else begin
          victim_q <= victim;
          evict_q  <= cache_populated;
          if (miss_q != 32'hFFFF_FFFF)
            miss_q <= miss_q + 32'd1;
        end
      end
      if (state == MISS_WAIT && mem_resp_valid)
        block_q <= mem_resp_data;
      if (state == FILL)
        resp_q <= block_q;
    end
  end

endmodule
